// File: rtl/cnn_tile_ctrl.sv
// cnn_tile_ctrl: sequences one 3x3/pad-1 conv layer over output tiles, prefetching IFM rows
// into a ring buffer and scanning pixels x input tiles to the PE array.
module cnn_tile_ctrl #(
  parameter int W_SIZE       = 12,
  parameter int W_CHANNEL    = 6,
  parameter int W_FRAME_SIZE = 32,
  parameter int W_DELAY      = 8,
  parameter int H_GAP        = 8,
  parameter int IFM_BUF_CNT  = 4,
  parameter int W_IFM_BUF    = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    q_start,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_SIZE-1:0]       q_height,
  input  logic [W_CHANNEL-1:0]    q_in_tiles,
  input  logic [W_CHANNEL-1:0]    q_out_tiles,
  input  logic                    q_stride2,
  input  logic                    q_filter_buf_done,
  input  logic                    q_ifm_buf_done,
  input  logic                    q_pe_done,
  output logic                    o_busy,
  output logic                    o_filter_req_load,
  output logic [W_CHANNEL-1:0]    o_filter_req_tile,
  output logic                    o_ifm_buf_req_load,
  output logic [W_SIZE-1:0]       o_ifm_buf_req_row,
  output logic [W_IFM_BUF-1:0]    o_ifm_buf_req_slot,
  output logic                    o_data_run,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_CHANNEL-1:0]    o_chn,
  output logic [W_CHANNEL-1:0]    o_otile,
  output logic                    o_is_first_row,
  output logic                    o_is_last_row,
  output logic                    o_is_first_col,
  output logic                    o_is_last_col,
  output logic [W_FRAME_SIZE-1:0] o_data_count,
  output logic                    o_end_frame
);
  typedef enum logic [2:0] {IDLE, LOAD_FLT, ROW_WAIT, HSYNC, DATA, WAIT_PE, NEXT_ROW, DONE} state_t;
  state_t state, nxt;
  logic [W_SIZE-1:0] cfg_h, oh, ow, nlr, col_n;
  logic [W_CHANNEL-1:0] cfg_in, cfg_out, chn_n;
  logic cfg_s2, pending, pe_flag, active, issue, run_n;
  logic [W_DELAY-1:0] gap;
  logic [W_SIZE:0] ir, lo, hi, nlr_n;
  logic last_chn, last_col, last_row, last_tile, rows_ready, degen;
  // ir is the input centre row; [lo,hi] is the clamped 3-row window it needs
  assign ir = cfg_s2 ? {o_row, 1'b0} : {1'b0, o_row};
  assign lo = (ir == '0) ? '0 : ir - 1'b1;
  assign hi = (ir + 1'b1 >= {1'b0, cfg_h}) ? {1'b0, cfg_h} - 1'b1 : ir + 1'b1;
  assign nlr_n = {1'b0, nlr} + (W_SIZE+1)'(pending & q_ifm_buf_done);
  assign rows_ready = nlr_n > hi;
  assign last_chn = o_chn == cfg_in - 1'b1;
  assign last_col = o_col == ow - 1'b1;
  assign last_row = o_row == oh - 1'b1;
  assign last_tile = o_otile == cfg_out - 1'b1;
  assign degen = (q_width == '0) || (q_height == '0) || (q_in_tiles == '0) || (q_out_tiles == '0);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (q_start) nxt = degen ? DONE : LOAD_FLT;
      LOAD_FLT: if (q_filter_buf_done) nxt = ROW_WAIT;
      ROW_WAIT: if (rows_ready) nxt = HSYNC;
      HSYNC:    if (gap == W_DELAY'(H_GAP - 1)) nxt = DATA;
      DATA:     if (last_chn && last_col) nxt = WAIT_PE;
      WAIT_PE:  if (pe_flag || q_pe_done) nxt = NEXT_ROW;
      NEXT_ROW: nxt = !last_row ? ROW_WAIT : !last_tile ? LOAD_FLT : DONE;
      default:  nxt = IDLE;
    endcase
  end
  // a done pulse in the same cycle frees the slot, so the next request goes out back-to-back
  always_comb begin
    active = nxt inside {ROW_WAIT, HSYNC, DATA, WAIT_PE, NEXT_ROW};
    issue = active && (!pending || q_ifm_buf_done) && (nlr_n < {1'b0, cfg_h})
            && (nlr_n < lo + (W_SIZE+1)'(IFM_BUF_CNT));
    chn_n = (state != DATA || last_chn) ? '0 : o_chn + 1'b1;
    col_n = (state != DATA || (last_chn && last_col)) ? '0 : last_chn ? o_col + 1'b1 : o_col;
    run_n = nxt == DATA;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cfg_h <= '0;
      cfg_in <= '0;
      cfg_out <= '0;
      cfg_s2 <= 1'b0;
      oh <= '0;
      ow <= '0;
      nlr <= '0;
      pending <= 1'b0;
      pe_flag <= 1'b0;
      gap <= '0;
      o_busy <= 1'b0;
      o_filter_req_load <= 1'b0;
      o_filter_req_tile <= '0;
      o_ifm_buf_req_load <= 1'b0;
      o_ifm_buf_req_row <= '0;
      o_ifm_buf_req_slot <= '0;
      o_data_run <= 1'b0;
      o_row <= '0;
      o_col <= '0;
      o_chn <= '0;
      o_otile <= '0;
      o_is_first_row <= 1'b0;
      o_is_last_row <= 1'b0;
      o_is_first_col <= 1'b0;
      o_is_last_col <= 1'b0;
      o_data_count <= '0;
      o_end_frame <= 1'b0;
    end else begin
      if (state == IDLE && q_start) begin
        cfg_h <= q_height;
        cfg_in <= q_in_tiles;
        cfg_out <= q_out_tiles;
        cfg_s2 <= q_stride2;
        oh <= q_stride2 ? q_height >> 1 : q_height;
        ow <= q_stride2 ? q_width >> 1 : q_width;
        o_data_count <= '0;
        o_otile <= '0;
        o_filter_req_tile <= '0;
        o_row <= '0;
      end else o_data_count <= o_data_count + W_FRAME_SIZE'(run_n);
      if (state == NEXT_ROW) begin
        o_row <= last_row ? '0 : o_row + 1'b1;
        if (last_row && !last_tile) begin
          o_otile <= o_otile + 1'b1;
          o_filter_req_tile <= o_otile + 1'b1;
        end
      end
      nlr <= (state == LOAD_FLT) ? '0 : nlr_n[W_SIZE-1:0];
      pending <= issue || (pending && !q_ifm_buf_done);
      o_ifm_buf_req_load <= issue;
      if (issue) begin
        o_ifm_buf_req_row <= nlr_n[W_SIZE-1:0];
        o_ifm_buf_req_slot <= nlr_n[W_IFM_BUF-1:0];
      end
      o_filter_req_load <= (nxt == LOAD_FLT) && (state != LOAD_FLT);
      gap <= (state == HSYNC) ? gap + 1'b1 : '0;
      pe_flag <= (state == DATA) && (pe_flag || q_pe_done);
      o_data_run <= run_n;
      o_col <= col_n;
      o_chn <= chn_n;
      o_is_first_row <= run_n && o_row == '0;
      o_is_last_row <= run_n && last_row;
      o_is_first_col <= run_n && col_n == '0;
      o_is_last_col <= run_n && col_n == ow - 1'b1;
      o_busy <= nxt != IDLE;
      o_end_frame <= state == DONE;
    end
endmodule

// File: tb/tb_cnn_tile_ctrl.sv
// tb_cnn_tile_ctrl: directed frames with bench-side filter/IFM/PE responders and a scan model.
module tb_cnn_tile_ctrl;
  logic clk, rstn, q_start, q_stride2, q_filter_buf_done, q_ifm_buf_done, q_pe_done;
  logic [11:0] q_width, q_height;
  logic [5:0] q_in_tiles, q_out_tiles;
  logic o_busy, o_filter_req_load, o_ifm_buf_req_load, o_data_run, o_end_frame;
  logic o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col;
  logic [5:0] o_filter_req_tile, o_chn, o_otile;
  logic [11:0] o_ifm_buf_req_row, o_row, o_col;
  logic [1:0] o_ifm_buf_req_slot;
  logic [31:0] o_data_count;
  logic any_out;
  int vectors, miscompares;
  int cfg_w, cfg_h, cfg_in, cfg_s2, ifm_lat, pe_lat;
  int loaded, beat, beats, ends, f_cnt, i_cnt, p_cnt;
  int s, ow, oh, ipr, er, ec, ech, hi, lo;
  bit prev_run;
  int flt_tiles[$], ifm_rows[$];

  cnn_tile_ctrl dut (
    .clk(clk), .rstn(rstn), .q_start(q_start), .q_width(q_width), .q_height(q_height),
    .q_in_tiles(q_in_tiles), .q_out_tiles(q_out_tiles), .q_stride2(q_stride2),
    .q_filter_buf_done(q_filter_buf_done), .q_ifm_buf_done(q_ifm_buf_done), .q_pe_done(q_pe_done),
    .o_busy(o_busy), .o_filter_req_load(o_filter_req_load), .o_filter_req_tile(o_filter_req_tile),
    .o_ifm_buf_req_load(o_ifm_buf_req_load), .o_ifm_buf_req_row(o_ifm_buf_req_row),
    .o_ifm_buf_req_slot(o_ifm_buf_req_slot), .o_data_run(o_data_run), .o_row(o_row),
    .o_col(o_col), .o_chn(o_chn), .o_otile(o_otile), .o_is_first_row(o_is_first_row),
    .o_is_last_row(o_is_last_row), .o_is_first_col(o_is_first_col),
    .o_is_last_col(o_is_last_col), .o_data_count(o_data_count), .o_end_frame(o_end_frame)
  );

  assign any_out = |{o_busy, o_filter_req_load, o_filter_req_tile, o_ifm_buf_req_load,
                     o_ifm_buf_req_row, o_ifm_buf_req_slot, o_data_run, o_row, o_col, o_chn,
                     o_otile, o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col,
                     o_data_count, o_end_frame};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // responders (fixed latencies) and the scan model, all sampled on the falling edge
  always @(negedge clk) begin
    if (q_ifm_buf_done) loaded++;
    q_ifm_buf_done = 1'b0;
    q_filter_buf_done = 1'b0;
    q_pe_done = 1'b0;
    if (!rstn) begin
      f_cnt = 0;
      i_cnt = 0;
      p_cnt = 0;
      prev_run = 1'b0;
    end else begin
      if (f_cnt == 1) q_filter_buf_done = 1'b1;
      if (i_cnt == 1) q_ifm_buf_done = 1'b1;
      if (p_cnt == 1) q_pe_done = 1'b1;
      if (f_cnt != 0) f_cnt--;
      if (i_cnt != 0) i_cnt--;
      if (p_cnt != 0) p_cnt--;
      s = cfg_s2 + 1;
      ow = cfg_w / s;
      oh = cfg_h / s;
      if (o_filter_req_load) begin
        flt_tiles.push_back(int'(o_filter_req_tile));
        loaded = 0;
        beat = 0;
        f_cnt = 3;
      end
      if (o_ifm_buf_req_load) begin
        lo = int'(o_row) * s - 1;
        if (lo < 0) lo = 0;
        chk("one_outstanding", i_cnt == 0, 1);
        chk("slot", o_ifm_buf_req_slot, o_ifm_buf_req_row % 4);
        chk("window", int'(o_ifm_buf_req_row) - lo < 4, 1);
        ifm_rows.push_back(int'(o_ifm_buf_req_row));
        i_cnt = ifm_lat;
      end
      if (o_data_run) begin
        ipr = cfg_in * ow;
        er = beat / ipr;
        ec = (beat % ipr) / cfg_in;
        ech = beat % cfg_in;
        hi = (er * s + 1 > cfg_h - 1) ? cfg_h - 1 : er * s + 1;
        chk("scan", {23'd0, loaded > hi, o_otile, o_row, o_col, o_chn,
                     o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col},
                    {23'd0, 1'b1, 6'(flt_tiles.size() - 1), 12'(er), 12'(ec), 6'(ech),
                     er == 0, er == oh - 1, ec == 0, ec == ow - 1});
        beat++;
        beats++;
      end
      if (o_data_run && !prev_run) p_cnt = pe_lat;
      prev_run = o_data_run;
      if (o_end_frame) ends++;
    end
  end

  task automatic start_frame(input int w, h, ni, no, s2, il, pl);
    cfg_w = w;
    cfg_h = h;
    cfg_in = ni;
    cfg_s2 = s2;
    ifm_lat = il;
    pe_lat = pl;
    ends = 0;
    beats = 0;
    flt_tiles.delete();
    ifm_rows.delete();
    q_width = 12'(w);
    q_height = 12'(h);
    q_in_tiles = 6'(ni);
    q_out_tiles = 6'(no);
    q_stride2 = s2 != 0;
    q_start = 1'b1;
    @(negedge clk);
    q_start = 1'b0;
    q_width = 12'd3;
    q_height = 12'd5;
    q_in_tiles = 6'd7;
    q_out_tiles = 6'd9;
    q_stride2 = s2 == 0;
  endtask

  task automatic run_frame(input int w, h, ni, no, s2, il, pl, exp_n, input bit poke);
    start_frame(w, h, ni, no, s2, il, pl);
    chk("busy_on", o_busy, 1);
    chk("flt_req_on", o_filter_req_load, 1);
    for (int i = 0; i < 20000 && ends == 0; i++) begin
      q_start = poke && i == 30;
      @(negedge clk);
    end
    q_start = 1'b0;
    chk("end_seen", ends, 1);
    repeat (3) @(negedge clk);
    chk("end_once", ends, 1);
    chk("busy_off", o_busy, 0);
    chk("beats", beats, exp_n);
    chk("data_count", o_data_count, exp_n);
    chk("flt_n", flt_tiles.size(), no);
    foreach (flt_tiles[i]) chk("flt_tile", flt_tiles[i], i);
    chk("ifm_n", ifm_rows.size(), h * no);
    foreach (ifm_rows[i]) chk("ifm_row", ifm_rows[i], i % h);
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: simulation ran out of cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rstn = 1'b0;
    q_start = 1'b0;
    q_width = '0;
    q_height = '0;
    q_in_tiles = '0;
    q_out_tiles = '0;
    q_stride2 = 1'b0;
    cfg_w = 1;
    cfg_h = 1;
    cfg_in = 1;
    cfg_s2 = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", any_out, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outs", any_out, 0);
    run_frame(8, 4, 2, 1, 0, 10, 3, 64, 1'b0);
    run_frame(8, 8, 1, 1, 1, 10, 40, 16, 1'b0);
    run_frame(8, 4, 2, 2, 0, 10, 3, 128, 1'b1);
    run_frame(8, 4, 1, 1, 0, 2048, 3, 32, 1'b0);
    start_frame(8, 4, 2, 1, 0, 10, 3);
    for (int i = 0; i < 2000 && !o_data_run; i++) @(negedge clk);
    chk("reach_data", o_data_run, 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_outs", any_out, 0);
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_end", ends, 0);
    chk("abort_idle", any_out, 0);
    run_frame(8, 4, 2, 1, 0, 10, 3, 64, 1'b0);
    start_frame(0, 4, 2, 1, 0, 10, 3);
    chk("deg_busy", o_busy, 1);
    chk("deg_end_early", o_end_frame, 0);
    @(negedge clk);
    chk("deg_end", o_end_frame, 1);
    @(negedge clk);
    chk("deg_end_pulse", o_end_frame, 0);
    chk("deg_busy_off", o_busy, 0);
    chk("deg_count", o_data_count, 0);
    chk("deg_flt_n", flt_tiles.size(), 0);
    chk("deg_ifm_n", ifm_rows.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
